// File: rtl/enc_8b10b_pkg.sv
// Shared 8b/10b code tables and helpers for the multi-byte PCS encoder.
// 6b codes are held as abcdei and 4b codes as fghj, MSB first.
package enc_8b10b_pkg;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [9:0] K28_5_NEG = 10'h17C;
  localparam logic [9:0] K28_5_POS = 10'h283;

  typedef struct packed {
    logic [5:0] neg;
    logic [5:0] pos;
  } code6_t;

  typedef struct packed {
    logic [3:0] neg;
    logic [3:0] pos;
  } code4_t;

  localparam logic [5:0] D6_NEG [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
  };

  localparam logic [3:0] D4_NEG [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
  };

  localparam logic [3:0] K4_NEG [8] = '{
    4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111
  };

  // Unbalanced codes swap to their complement under RD+; D.7 is balanced but swaps too.
  function automatic code6_t enc_5b6b(input logic [4:0] x, input logic k28);
    code6_t c;
    logic [5:0] n;
    n     = k28 ? 6'b001111 : D6_NEG[x];
    c.neg = n;
    c.pos = (($countones(n) != 3) || (!k28 && x == 5'd7)) ? ~n : n;
    return c;
  endfunction

  // K columns and D.x.3 always complement; A7 overrides the primary D.x.7 code.
  function automatic code4_t enc_3b4b(input logic [2:0] y, input logic k, input logic a7);
    code4_t c;
    logic [3:0] n;
    n     = k ? K4_NEG[y] : (a7 ? 4'b0111 : D4_NEG[y]);
    c.neg = n;
    c.pos = (k || y == 3'd3 || ($countones(n) != 2)) ? ~n : n;
    return c;
  endfunction

  function automatic logic is_legal_k(input logic [7:0] b);
    logic [4:0] x;
    x = b[4:0];
    return (x == 5'd28) ||
           (b[7:5] == 3'd7 && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30));
  endfunction

  function automatic logic next_rd6(input logic [5:0] c, input logic rd);
    return ($countones(c) > 3) ? 1'b1 : (($countones(c) < 3) ? 1'b0 : rd);
  endfunction

  function automatic logic next_rd4(input logic [3:0] c, input logic rd);
    return ($countones(c) > 2) ? 1'b1 : (($countones(c) < 2) ? 1'b0 : rd);
  endfunction

  // Table order (a first) to symbol bit order (a at bit 0).
  function automatic logic [5:0] rev6(input logic [5:0] c);
    return {c[0], c[1], c[2], c[3], c[4], c[5]};
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] c);
    return {c[0], c[1], c[2], c[3]};
  endfunction

endpackage

// File: rtl/enc_8b10b_multi_if.sv
// Word-level bus between the PCS transmit logic and the 8b/10b encoder.
interface enc_8b10b_multi_if #(parameter int BYTES = 2);
  logic                  enable;
  logic [8*BYTES-1:0]    data;
  logic [BYTES-1:0]      TXDataK;
  logic                  TxCompliance;
  logic                  enable_PMA;
  logic [10*BYTES-1:0]   data_out;
  logic [BYTES-1:0]      code_err;
  logic                  rd_out;

  modport master (
    output enable, data, TXDataK, TxCompliance,
    input  enable_PMA, data_out, code_err, rd_out
  );

  modport slave (
    input  enable, data, TXDataK, TxCompliance,
    output enable_PMA, data_out, code_err, rd_out
  );
endinterface

// File: rtl/enc_8b10b_byte.sv
// Combinational single-byte 8b/10b encoder; illegal K bytes fall back to the D code.
module enc_8b10b_byte
  import enc_8b10b_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       k_i,
  input  logic       rd_i,
  output logic [9:0] sym_o,
  output logic       rd_o,
  output logic       err_o
);

  logic [4:0] x;
  logic [2:0] y;
  logic       legal;
  logic       use_k;
  logic       rd6;
  logic       a7;
  code6_t     c6;
  code4_t     c4;
  logic [5:0] six;
  logic [3:0] four;

  assign x = data_i[4:0];
  assign y = data_i[7:5];

  always_comb begin
    legal = is_legal_k(data_i);
    use_k = k_i && legal;
    err_o = k_i && !legal;
    c6    = enc_5b6b(x, use_k && (x == 5'd28));
    six   = rd_i ? c6.pos : c6.neg;
    rd6   = next_rd6(six, rd_i);
    // A7 avoids a run of five equal bits across the e/i/f/g/h boundary.
    a7    = !use_k && (y == 3'd7) &&
            ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
             ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
    c4    = enc_3b4b(y, use_k, a7);
    four  = rd6 ? c4.pos : c4.neg;
    rd_o  = next_rd4(four, rd6);
    sym_o = {rev4(four), rev6(six)};
  end

endmodule

// File: rtl/enc_8b10b_multi.sv
// Multi-byte 8b/10b encoder: BYTES chained byte encoders feeding one output register stage.
// Running disparity flows byte 0 -> BYTES-1 and is carried between words in rd_q.
module enc_8b10b_multi
  import enc_8b10b_pkg::*;
#(
  parameter int BYTES = 2
) (
  input  logic                     Bit_Rate_10,
  input  logic                     Rst,
  enc_8b10b_multi_if.slave         enc_if
);

  logic [10*BYTES-1:0] sym;
  logic [BYTES-1:0]    err;
  logic                rd_chain [BYTES+1];

  logic                valid_q, valid_d;
  logic [10*BYTES-1:0] sym_q, sym_d;
  logic [BYTES-1:0]    err_q, err_d;
  logic                rd_q, rd_d;

  // Compliance patterns must start from RD- regardless of the carried disparity.
  assign rd_chain[0] = (enc_if.TxCompliance && enc_if.TXDataK[0]) ? 1'b0 : rd_q;

  for (genvar i = 0; i < BYTES; i++) begin : g_byte
    enc_8b10b_byte u_byte (
      .data_i (enc_if.data[8*i +: 8]),
      .k_i    (enc_if.TXDataK[i]),
      .rd_i   (rd_chain[i]),
      .sym_o  (sym[10*i +: 10]),
      .rd_o   (rd_chain[i+1]),
      .err_o  (err[i])
    );
  end

  always_comb begin
    valid_d = enc_if.enable;
    sym_d   = sym_q;
    err_d   = err_q;
    rd_d    = rd_q;
    if (enc_if.enable) begin
      sym_d = sym;
      err_d = err;
      rd_d  = rd_chain[BYTES];
    end
  end

  always_ff @(posedge Bit_Rate_10 or negedge Rst) begin
    if (!Rst) begin
      valid_q <= 1'b0;
      sym_q   <= '0;
      err_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sym_q   <= sym_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  assign enc_if.enable_PMA = valid_q;
  assign enc_if.data_out   = sym_q;
  assign enc_if.code_err   = err_q;
  assign enc_if.rd_out     = rd_q;

endmodule

// File: tb/tb_enc_8b10b_multi.sv
// Directed bench for enc_8b10b_multi: a 1-byte and a 2-byte instance sharing clock and reset.
module tb_enc_8b10b_multi;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  enc_8b10b_multi_if #(.BYTES(1)) i1 ();
  enc_8b10b_multi_if #(.BYTES(2)) i2 ();

  enc_8b10b_multi #(.BYTES(1)) dut1 (.Bit_Rate_10(clk), .Rst(rst_n), .enc_if(i1));
  enc_8b10b_multi #(.BYTES(2)) dut2 (.Bit_Rate_10(clk), .Rst(rst_n), .enc_if(i2));

  always #5 clk = ~clk;

  task automatic drive1(input logic en, input logic k, input logic [7:0] d, input logic comp);
    i1.enable = en; i1.TXDataK = k; i1.data = d; i1.TxCompliance = comp;
    @(posedge clk); #1;
  endtask

  task automatic drive2(input logic en, input logic [1:0] k, input logic [15:0] d, input logic comp);
    i2.enable = en; i2.TXDataK = k; i2.data = d; i2.TxCompliance = comp;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    i1.enable = 1'b1; i1.TXDataK = 1'b1; i1.data = 8'hBC; i1.TxCompliance = 1'b0;
    i2.enable = 1'b1; i2.TXDataK = 2'b11; i2.data = 16'hBCBC; i2.TxCompliance = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (i1.enable_PMA !== 1'b0) begin errors++; $display("FAIL reset_en1: got %b want 0", i1.enable_PMA); end
    checks++; if (i1.data_out !== 10'h000) begin errors++; $display("FAIL reset_data1: got %h want 000", i1.data_out); end
    checks++; if (i1.code_err !== 1'b0 || i1.rd_out !== 1'b0) begin errors++; $display("FAIL reset_err_rd1: got err=%b rd=%b want 0/0", i1.code_err, i1.rd_out); end
    checks++; if (i2.enable_PMA !== 1'b0 || i2.data_out !== 20'h0) begin errors++; $display("FAIL reset_2: got en=%b data=%h want 0/00000", i2.enable_PMA, i2.data_out); end
    checks++; if (i2.code_err !== 2'b00 || i2.rd_out !== 1'b0) begin errors++; $display("FAIL reset_err_rd2: got err=%b rd=%b want 00/0", i2.code_err, i2.rd_out); end
    i2.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_k28_5_alt;
    logic [9:0] exp_sym [3];
    logic       exp_rd  [3];
    exp_sym = '{10'h17C, 10'h283, 10'h17C};
    exp_rd  = '{1'b1, 1'b0, 1'b1};
    for (int n = 0; n < 3; n++) begin
      drive1(1'b1, 1'b1, 8'hBC, 1'b0);
      checks++;
      if (i1.data_out !== exp_sym[n] || i1.rd_out !== exp_rd[n] || i1.enable_PMA !== 1'b1 || i1.code_err !== 1'b0) begin
        errors++;
        $display("FAIL k28_5_alt[%0d]: got data=%h rd=%b en=%b err=%b want %h/%b/1/0",
                 n, i1.data_out, i1.rd_out, i1.enable_PMA, i1.code_err, exp_sym[n], exp_rd[n]);
      end
    end
  endtask

  task automatic test_d0_0;
    drive1(1'b1, 1'b1, 8'hBC, 1'b0);
    checks++; if (i1.data_out !== 10'h283 || i1.rd_out !== 1'b0) begin errors++; $display("FAIL d0_0_pre: got %h/%b want 283/0", i1.data_out, i1.rd_out); end
    drive1(1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (i1.data_out !== 10'h0B9 || i1.rd_out !== 1'b0) begin errors++; $display("FAIL d0_0_neg: got %h/%b want 0b9/0", i1.data_out, i1.rd_out); end
    drive1(1'b1, 1'b1, 8'hBC, 1'b0);
    checks++; if (i1.data_out !== 10'h17C || i1.rd_out !== 1'b1) begin errors++; $display("FAIL d0_0_mid: got %h/%b want 17c/1", i1.data_out, i1.rd_out); end
    drive1(1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (i1.data_out !== 10'h346 || i1.rd_out !== 1'b1) begin errors++; $display("FAIL d0_0_pos: got %h/%b want 346/1", i1.data_out, i1.rd_out); end
  endtask

  task automatic test_d21_5;
    drive1(1'b1, 1'b0, 8'hB5, 1'b0);
    checks++; if (i1.data_out !== 10'h155 || i1.rd_out !== 1'b1) begin errors++; $display("FAIL d21_5_pos: got %h/%b want 155/1", i1.data_out, i1.rd_out); end
    drive1(1'b1, 1'b1, 8'hBC, 1'b0);
    checks++; if (i1.data_out !== 10'h283 || i1.rd_out !== 1'b0) begin errors++; $display("FAIL d21_5_pre: got %h/%b want 283/0", i1.data_out, i1.rd_out); end
    drive1(1'b1, 1'b0, 8'hB5, 1'b0);
    checks++; if (i1.data_out !== 10'h155 || i1.rd_out !== 1'b0) begin errors++; $display("FAIL d21_5_neg: got %h/%b want 155/0", i1.data_out, i1.rd_out); end
  endtask

  task automatic test_alt7;
    drive1(1'b1, 1'b0, 8'hF1, 1'b0);
    checks++; if (i1.data_out[9:6] !== 4'b1110) begin errors++; $display("FAIL d17_7_jhgf: got %b want 1110", i1.data_out[9:6]); end
    checks++; if (i1.data_out !== 10'h3B1 || i1.rd_out !== 1'b1) begin errors++; $display("FAIL d17_7: got %h/%b want 3b1/1", i1.data_out, i1.rd_out); end
    drive1(1'b1, 1'b0, 8'hEB, 1'b0);
    checks++; if (i1.data_out !== 10'h04B || i1.rd_out !== 1'b0) begin errors++; $display("FAIL d11_7: got %h/%b want 04b/0", i1.data_out, i1.rd_out); end
  endtask

  task automatic test_illegal_k;
    drive1(1'b1, 1'b1, 8'h00, 1'b0);
    checks++; if (i1.code_err !== 1'b1 || i1.data_out !== 10'h0B9 || i1.rd_out !== 1'b0) begin errors++; $display("FAIL illegal_k: got err=%b %h/%b want 1 0b9/0", i1.code_err, i1.data_out, i1.rd_out); end
    drive1(1'b1, 1'b1, 8'hBC, 1'b0);
    checks++; if (i1.code_err !== 1'b0 || i1.data_out !== 10'h17C || i1.rd_out !== 1'b1) begin errors++; $display("FAIL after_illegal: got err=%b %h/%b want 0 17c/1", i1.code_err, i1.data_out, i1.rd_out); end
    drive1(1'b1, 1'b1, 8'hF7, 1'b0);
    checks++; if (i1.code_err !== 1'b0 || i1.data_out !== 10'h3A8 || i1.rd_out !== 1'b1) begin errors++; $display("FAIL k23_7: got err=%b %h/%b want 0 3a8/1", i1.code_err, i1.data_out, i1.rd_out); end
  endtask

  task automatic test_gap;
    drive1(1'b0, 1'b1, 8'h00, 1'b1);
    checks++; if (i1.enable_PMA !== 1'b0 || i1.data_out !== 10'h3A8 || i1.rd_out !== 1'b1 || i1.code_err !== 1'b0) begin errors++; $display("FAIL gap_0: got en=%b %h/%b err=%b want 0 3a8/1 0", i1.enable_PMA, i1.data_out, i1.rd_out, i1.code_err); end
    drive1(1'b0, 1'b1, 8'hBC, 1'b1);
    checks++; if (i1.enable_PMA !== 1'b0 || i1.data_out !== 10'h3A8 || i1.rd_out !== 1'b1 || i1.code_err !== 1'b0) begin errors++; $display("FAIL gap_1: got en=%b %h/%b err=%b want 0 3a8/1 0", i1.enable_PMA, i1.data_out, i1.rd_out, i1.code_err); end
    drive1(1'b1, 1'b1, 8'hBC, 1'b0);
    checks++; if (i1.enable_PMA !== 1'b1 || i1.data_out !== 10'h283 || i1.rd_out !== 1'b0) begin errors++; $display("FAIL gap_resume: got en=%b %h/%b want 1 283/0", i1.enable_PMA, i1.data_out, i1.rd_out); end
  endtask

  task automatic test_compliance;
    drive1(1'b1, 1'b1, 8'hBC, 1'b0);
    checks++; if (i1.data_out !== 10'h17C || i1.rd_out !== 1'b1) begin errors++; $display("FAIL comp_pre: got %h/%b want 17c/1", i1.data_out, i1.rd_out); end
    drive1(1'b1, 1'b1, 8'hBC, 1'b1);
    checks++; if (i1.data_out !== 10'h17C || i1.rd_out !== 1'b1) begin errors++; $display("FAIL comp_force: got %h/%b want 17c/1", i1.data_out, i1.rd_out); end
    drive1(1'b1, 1'b1, 8'hBC, 1'b0);
    checks++; if (i1.data_out !== 10'h283 || i1.rd_out !== 1'b0) begin errors++; $display("FAIL comp_after: got %h/%b want 283/0", i1.data_out, i1.rd_out); end
    i1.enable = 1'b0;
  endtask

  task automatic test_multi_byte;
    drive2(1'b1, 2'b11, 16'hBCBC, 1'b0);
    checks++; if (i2.data_out !== 20'hA0D7C || i2.rd_out !== 1'b0 || i2.code_err !== 2'b00) begin errors++; $display("FAIL multi_k28_5: got %h/%b err=%b want a0d7c/0 00", i2.data_out, i2.rd_out, i2.code_err); end
    drive2(1'b1, 2'b10, 16'h00F1, 1'b0);
    checks++; if (i2.data_out !== 20'hD1BB1 || i2.rd_out !== 1'b1 || i2.code_err !== 2'b10) begin errors++; $display("FAIL multi_chain: got %h/%b err=%b want d1bb1/1 10", i2.data_out, i2.rd_out, i2.code_err); end
    drive2(1'b1, 2'b11, 16'hBCBC, 1'b1);
    checks++; if (i2.data_out !== 20'hA0D7C || i2.rd_out !== 1'b0 || i2.code_err !== 2'b00) begin errors++; $display("FAIL multi_comp: got %h/%b err=%b want a0d7c/0 00", i2.data_out, i2.rd_out, i2.code_err); end
    i2.enable = 1'b0;
  endtask

  task automatic test_mid_reset;
    drive1(1'b1, 1'b1, 8'hBC, 1'b0);
    checks++; if (i1.data_out !== 10'h17C || i1.rd_out !== 1'b1) begin errors++; $display("FAIL mrst_pre: got %h/%b want 17c/1", i1.data_out, i1.rd_out); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (i1.enable_PMA !== 1'b0 || i1.data_out !== 10'h000 || i1.rd_out !== 1'b0 || i1.code_err !== 1'b0) begin errors++; $display("FAIL mrst_async: got en=%b %h/%b err=%b want 0 000/0 0", i1.enable_PMA, i1.data_out, i1.rd_out, i1.code_err); end
    checks++; if (i2.data_out !== 20'h0 || i2.rd_out !== 1'b0) begin errors++; $display("FAIL mrst_async2: got %h/%b want 00000/0", i2.data_out, i2.rd_out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (i1.enable_PMA !== 1'b1 || i1.data_out !== 10'h17C || i1.rd_out !== 1'b1) begin errors++; $display("FAIL mrst_restart: got en=%b %h/%b want 1 17c/1", i1.enable_PMA, i1.data_out, i1.rd_out); end
    i1.enable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    i1.enable = 1'b0; i1.TXDataK = 1'b0; i1.data = 8'h00; i1.TxCompliance = 1'b0;
    i2.enable = 1'b0; i2.TXDataK = 2'b00; i2.data = 16'h0000; i2.TxCompliance = 1'b0;
    test_reset();
    test_k28_5_alt();
    test_d0_0();
    test_d21_5();
    test_alt7();
    test_illegal_k();
    test_gap();
    test_compliance();
    test_multi_byte();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
